amp_i2c_slave: RTL and testbench

I2C target (responder) for the amplifier-side register bank: decodes I2C write and read transactions addressed to a fixed 7-bit device address and converts them into single-cycle register-bus strobes. It is the counterpart of our hardcoded I2C boot master and lets a bench or a host MCU program the amp registers in-system. It sits between the open-drain pad logic (SDA input plus a pull-low enable; SCL input only) and the register file.

---
 rtl/amp_i2c_pkg.sv | 34 +++
 rtl/i2c_line_filter.sv | 66 ++++++
 rtl/amp_i2c_slave.sv | 239 +++++++++++++++++++++++
 tb/tb_amp_i2c_slave.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_i2c_pkg.sv
// amp_i2c_pkg
// Shared definitions for the amplifier-side I2C target:
//   - FSM state encoding (plain localparam constants)
//   - I2C_WR / I2C_RD values of the R/W bit
//   - default 7-bit device address
//   - addr_match() helper used by the address phase
package amp_i2c_pkg;

  typedef logic [3:0] i2c_state_t;

  localparam i2c_state_t ST_IDLE      = 4'd0;
  localparam i2c_state_t ST_ADDR      = 4'd1;
  localparam i2c_state_t ST_ADDR_ACK  = 4'd2;
  localparam i2c_state_t ST_PTR       = 4'd3;
  localparam i2c_state_t ST_PTR_ACK   = 4'd4;
  localparam i2c_state_t ST_WDATA     = 4'd5;
  localparam i2c_state_t ST_WDATA_ACK = 4'd6;
  localparam i2c_state_t ST_RDATA     = 4'd7;
  localparam i2c_state_t ST_MACK      = 4'd8;
  localparam i2c_state_t ST_IGNORE    = 4'd9;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h20;

  // True when the upper seven bits of a received address byte select us.
  // The general-call address 0x00 never matches a non-zero device address.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] dev_addr);
    return addr_byte[7:1] == dev_addr;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
// Conditions one asynchronous I2C pad input: a 2-FF synchronizer, then a
// glitch filter that accepts a new level only after FILT consecutive equal
// samples, then single-cycle rise/fall pulses on the filtered level.
// Pad-to-filtered-edge latency is 2 + FILT clocks.
// Ports:
//   clk_in  - system clock
//   resetb  - asynchronous active-low reset (line assumed idle high)
//   line_i  - raw pad input
//   line_o  - filtered line level
//   rise    - one-cycle pulse when line_o goes 0 -> 1
//   fall    - one-cycle pulse when line_o goes 1 -> 0
module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic clk_in,
  input  logic resetb,
  input  logic line_i,
  output logic line_o,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] CNT_MAX = 8'(FILT - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // Synchronizer; resets to the released (high) bus level so that leaving
  // reset on an idle bus does not look like an edge.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line_i;
      sync2 <= sync1;
    end
  end

  // cnt counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so short glitches are dropped.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      line_o <= 1'b1;
      cnt    <= 8'd0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == line_o) begin
        cnt <= 8'd0;
      end else if (cnt >= CNT_MAX) begin
        line_o <= sync2;
        cnt    <= 8'd0;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/amp_i2c_slave.sv
// amp_i2c_slave
// I2C target for the amplifier register bank. Decodes write and read
// transactions to DEV_ADDR and turns them into single-cycle register strobes.
// Ports:
//   clk_in    - system clock (>= 16x SCL)
//   resetb    - asynchronous active-low reset
//   scl_i     - raw SCL pad input
//   sda_i     - raw SDA pad input
//   sda_oe    - 1 pulls SDA low, 0 releases it
//   reg_addr  - register pointer (auto-increments, wraps, survives STOP)
//   reg_wdata - write data, valid with reg_we
//   reg_we    - one-cycle write strobe
//   reg_re    - one-cycle read request
//   reg_rdata - read data, returned one clock after reg_re
//   busy      - high from an accepted START/Sr until STOP
module amp_i2c_slave
  import amp_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         FILT     = 3
) (
  input  logic       clk_in,
  input  logic       resetb,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic       scl;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda;
  logic       sda_rise;
  logic       sda_fall;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .clk_in (clk_in),
    .resetb (resetb),
    .line_i (scl_i),
    .line_o (scl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .clk_in (clk_in),
    .resetb (resetb),
    .line_i (sda_i),
    .line_o (sda),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  i2c_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       re_d;

  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  // Byte as it stands including the bit sampled on this SCL rise.
  assign rx_byte   = {shift[6:0], sda};
  assign byte_done = scl_rise && (bit_cnt == 4'd7);

  // Main protocol FSM. START/STOP override every state. In the ACK states
  // the first SCL fall turns the ACK drive on and the second one ends the
  // ACK slot, so sda_oe itself marks which half of the slot we are in.
  // Read data is indexed MSB first by bit_cnt rather than shifted, so the
  // shift register keeps the prefetched byte intact for the whole byte.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      rw        <= I2C_WR;
      re_d      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_d   <= reg_re;
      // Register file answers one clock after reg_re.
      if (re_d) begin
        shift <= reg_rdata;
      end

      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (byte_done) begin
              bit_cnt <= 4'd0;
              if (addr_match(rx_byte, DEV_ADDR)) begin
                state <= ST_ADDR_ACK;
                rw    <= rx_byte[0];
                // Prefetch the first read byte at the current pointer.
                if (rx_byte[0] == I2C_RD) begin
                  reg_re <= 1'b1;
                end
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw == I2C_WR) begin
                state  <= ST_PTR;
                sda_oe <= 1'b0;
              end else begin
                state  <= ST_RDATA;
                sda_oe <= ~shift[7];
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (byte_done) begin
              bit_cnt  <= 4'd0;
              reg_addr <= rx_byte;
              state    <= ST_PTR_ACK;
            end
          end

          ST_PTR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                state  <= ST_WDATA;
                sda_oe <= 1'b0;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (byte_done) begin
              bit_cnt   <= 4'd0;
              reg_we    <= 1'b1;
              reg_wdata <= rx_byte;
              state     <= ST_WDATA_ACK;
            end
          end

          ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                state    <= ST_WDATA;
                sda_oe   <= 1'b0;
                reg_addr <= reg_addr + 8'd1;
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= ST_MACK;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
              end else begin
                sda_oe <= ~shift[~bit_cnt[2:0]];
              end
            end
          end

          ST_MACK: begin
            if (scl_rise) begin
              if (!sda) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= 1'b1;
                bit_cnt  <= 4'd0;
                state    <= ST_RDATA;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amp_i2c_slave.sv
// tb_amp_i2c_slave
// Directed bench for amp_i2c_slave: a bit-banged I2C master drives the pads,
// a small register-file model answers reg_re with addr ^ 8'h5A, and each
// test task compares observed behaviour against hand-computed values.
module tb_amp_i2c_slave;

  localparam int Q = 10;

  logic       clk_in = 1'b0;
  logic       resetb;
  logic       scl_m;
  logic       sda_m;
  logic       glitch;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'd0;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [7:0] re_addr_q[$];
  logic       oe_seen;
  int         both_cnt = 0;

  always #5 clk_in = ~clk_in;

  // Open-drain bus: master, target and glitch injector can all pull low.
  assign sda_line = sda_m & ~sda_oe & ~glitch;

  amp_i2c_slave #(.DEV_ADDR(7'h20), .FILT(3)) dut (
    .clk_in    (clk_in),
    .resetb    (resetb),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register file model: data appears one clock after the read request.
  always @(posedge clk_in) begin
    if (reg_re) reg_rdata <= reg_addr ^ 8'h5A;
  end

  // Strobe logger sampled on the inactive edge.
  always @(negedge clk_in) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  function automatic logic [7:0] q_at(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
    oe_seen = 1'b0;
  endtask

  // One SCL period starting and ending with SCL low; SDA only changes a
  // quarter period after SCL falls. Optional one-clock low glitch on SDA
  // in the middle of the high phase.
  task automatic clock_bit(input logic b, input logic g, output logic s);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    s = sda_line;
    if (g) begin
      glitch = 1'b1;
      wait_clk(1);
      glitch = 1'b0;
      wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], i == glitch_bit, s);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      b[i] = s;
    end
    clock_bit(mack, 1'b0, s);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    scl_m  = 1'b1;
    sda_m  = 1'b1;
    glitch = 1'b0;
    wait_clk(4);
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (reg_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_reg_we: got %b want 0", reg_we); end
    n_cmp++; if (reg_re !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_reg_re: got %b want 0", reg_re); end
    n_cmp++; if (reg_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_reg_addr: got %h want 00", reg_addr); end
    n_cmp++; if (reg_wdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_reg_wdata: got %h want 00", reg_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    resetb = 1'b1;
    wait_clk(Q);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'h40, -1, a0);
    write_byte(8'h40, -1, a1);
    write_byte(8'h18, -1, a2);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_busy: got %b want 1", busy); end
    i2c_stop();
    wait_clk(Q);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("[TB] FAIL wr_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_busy_stop: got %b want 0", busy); end
    n_cmp++; if (we_addr_q.size() != 1) begin n_fail++; $display("[TB] FAIL wr_we_count: got %0d want 1", we_addr_q.size()); end
    n_cmp++; if (q_at(we_addr_q, 0) !== 8'h40) begin n_fail++; $display("[TB] FAIL wr_we_addr: got %h want 40", q_at(we_addr_q, 0)); end
    n_cmp++; if (q_at(we_data_q, 0) !== 8'h18) begin n_fail++; $display("[TB] FAIL wr_we_data: got %h want 18", q_at(we_data_q, 0)); end
    n_cmp++; if (re_addr_q.size() != 0) begin n_fail++; $display("[TB] FAIL wr_re_count: got %0d want 0", re_addr_q.size()); end
    n_cmp++; if (reg_addr !== 8'h41) begin n_fail++; $display("[TB] FAIL wr_addr_inc: got %h want 41", reg_addr); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    clear_logs();
    i2c_start();
    write_byte(8'h40, -1, a0);
    write_byte(8'hFF, -1, a1);
    write_byte(8'hA1, -1, a2);
    write_byte(8'hB2, -1, a3);
    i2c_stop();
    wait_clk(Q);
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("[TB] FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
    n_cmp++; if (we_addr_q.size() != 2) begin n_fail++; $display("[TB] FAIL wrap_we_count: got %0d want 2", we_addr_q.size()); end
    n_cmp++; if ({q_at(we_addr_q, 0), q_at(we_data_q, 0)} !== 16'hFFA1) begin n_fail++; $display("[TB] FAIL wrap_first: got %h/%h want ff/a1", q_at(we_addr_q, 0), q_at(we_data_q, 0)); end
    n_cmp++; if ({q_at(we_addr_q, 1), q_at(we_data_q, 1)} !== 16'h00B2) begin n_fail++; $display("[TB] FAIL wrap_second: got %h/%h want 00/b2", q_at(we_addr_q, 1), q_at(we_data_q, 1)); end
  endtask

  task automatic test_ignore();
    logic a0, a1;
    clear_logs();
    i2c_start();
    write_byte(8'h42, -1, a0);
    write_byte(8'h55, -1, a1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_busy: got %b want 1", busy); end
    i2c_stop();
    wait_clk(Q);
    n_cmp++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("[TB] FAIL ign_nacks: got %b want 11", {a0, a1}); end
    n_cmp++; if (oe_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL ign_sda_oe: got %b want 0", oe_seen); end
    n_cmp++; if (we_addr_q.size() + re_addr_q.size() != 0) begin n_fail++; $display("[TB] FAIL ign_strobes: got %0d want 0", we_addr_q.size() + re_addr_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ign_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic       a0, a1, a2;
    logic [7:0] d0, d1;
    clear_logs();
    i2c_start();
    write_byte(8'h40, -1, a0);
    write_byte(8'h35, -1, a1);
    i2c_start();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_busy_sr: got %b want 1", busy); end
    write_byte(8'h41, -1, a2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    wait_clk(Q);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("[TB] FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (d0 !== 8'h6F) begin n_fail++; $display("[TB] FAIL rd_byte0: got %h want 6f", d0); end
    n_cmp++; if (d1 !== 8'h6C) begin n_fail++; $display("[TB] FAIL rd_byte1: got %h want 6c", d1); end
    n_cmp++; if (re_addr_q.size() != 2) begin n_fail++; $display("[TB] FAIL rd_re_count: got %0d want 2", re_addr_q.size()); end
    n_cmp++; if ({q_at(re_addr_q, 0), q_at(re_addr_q, 1)} !== 16'h3536) begin n_fail++; $display("[TB] FAIL rd_re_addrs: got %h,%h want 35,36", q_at(re_addr_q, 0), q_at(re_addr_q, 1)); end
    n_cmp++; if (we_addr_q.size() != 0) begin n_fail++; $display("[TB] FAIL rd_we_count: got %0d want 0", we_addr_q.size()); end
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'h40, -1, a0);
    write_byte(8'h50, -1, a1);
    write_byte(8'h77, 6, a2);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL gl_busy: got %b want 1", busy); end
    i2c_stop();
    wait_clk(Q);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("[TB] FAIL gl_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (we_addr_q.size() != 1) begin n_fail++; $display("[TB] FAIL gl_we_count: got %0d want 1", we_addr_q.size()); end
    n_cmp++; if ({q_at(we_addr_q, 0), q_at(we_data_q, 0)} !== 16'h5077) begin n_fail++; $display("[TB] FAIL gl_write: got %h/%h want 50/77", q_at(we_addr_q, 0), q_at(we_data_q, 0)); end
  endtask

  // Pointer is 0x51 here, so the prefetched byte is 0x51^0x5A = 0x0B and the
  // first four bits driven by the target are all zero (SDA pulled low).
  task automatic test_reset_mid_read();
    logic       a0, a1, a2, a3;
    logic [2:0] bits;
    logic       s;
    clear_logs();
    i2c_start();
    write_byte(8'h41, -1, a0);
    for (int i = 2; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      bits[i] = s;
    end
    n_cmp++; if ({a0, bits} !== 4'b0000) begin n_fail++; $display("[TB] FAIL mr_first_bits: got %b want 0000", {a0, bits}); end
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q / 2);
    n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL mr_drive_before: got %b want 1", sda_oe); end
    resetb = 1'b0;
    #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL mr_sda_oe_async: got %b want 0", sda_oe); end
    n_cmp++; if ({busy, reg_we, reg_re} !== 3'b000) begin n_fail++; $display("[TB] FAIL mr_flags: got %b want 000", {busy, reg_we, reg_re}); end
    n_cmp++; if ({reg_addr, reg_wdata} !== 16'h0000) begin n_fail++; $display("[TB] FAIL mr_regs: got %h want 0000", {reg_addr, reg_wdata}); end
    wait_clk(3);
    resetb = 1'b1;
    wait_clk(Q);
    clear_logs();
    i2c_start();
    write_byte(8'h40, -1, a1);
    write_byte(8'h12, -1, a2);
    write_byte(8'h9C, -1, a3);
    i2c_stop();
    wait_clk(Q);
    n_cmp++; if ({a1, a2, a3} !== 3'b000) begin n_fail++; $display("[TB] FAIL mr_after_acks: got %b want 000", {a1, a2, a3}); end
    n_cmp++; if (we_addr_q.size() != 1) begin n_fail++; $display("[TB] FAIL mr_after_count: got %0d want 1", we_addr_q.size()); end
    n_cmp++; if ({q_at(we_addr_q, 0), q_at(we_data_q, 0)} !== 16'h129C) begin n_fail++; $display("[TB] FAIL mr_after_write: got %h/%h want 12/9c", q_at(we_addr_q, 0), q_at(we_data_q, 0)); end
  endtask

  initial begin
    $display("[TB] amp_i2c_slave directed tests");
    test_reset();
    test_write();
    test_wrap();
    test_ignore();
    test_read();
    test_glitch();
    test_reset_mid_read();
    n_cmp++; if (both_cnt != 0) begin n_fail++; $display("[TB] FAIL we_re_overlap: got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
